// File: rtl/axis_pkg.sv
// axis_pkg: shared FSM encoding and default sizes for the packet arbiter
package axis_pkg;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 8;
  localparam int ID_W = 2;
  typedef enum logic {IDLE, XFER} state_t;
endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// axis_pkt_arbiter_if: upstream requester and downstream AXI-Stream bundle
interface axis_pkt_arbiter_if #(
  parameter int NUM_IN = axis_pkg::NUM_IN,
  parameter int DATA_W = axis_pkg::DATA_W,
  parameter int ID_W = axis_pkg::ID_W
);
  logic [NUM_IN*DATA_W-1:0] s_tdata;
  logic [NUM_IN-1:0] s_tvalid;
  logic [NUM_IN-1:0] s_tlast;
  logic [NUM_IN-1:0] s_tready;
  logic [NUM_IN-1:0] req_mask;
  logic [DATA_W-1:0] m_tdata;
  logic m_tvalid;
  logic m_tlast;
  logic [ID_W-1:0] m_tid;
  logic m_tready;
  logic busy;
  modport slave (
    input s_tdata, s_tvalid, s_tlast, req_mask, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid, busy
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, req_mask, m_tready,
    input s_tready, m_tdata, m_tvalid, m_tlast, m_tid, busy
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request searching upward from ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic gnt_any
);
  // scan from the farthest slot back toward ptr so the nearest hit wins
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_idx = IW'(idx);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-locked round-robin AXI-Stream arbiter with registered output
module axis_pkt_arbiter #(
  parameter int NUM_IN = axis_pkg::NUM_IN,
  parameter int DATA_W = axis_pkg::DATA_W,
  parameter int ID_W = axis_pkg::ID_W
) (
  input logic clk,
  input logic reset_n,
  axis_pkt_arbiter_if.slave bus
);
  import axis_pkg::*;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IN - 1);
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, pick_idx;
  logic pick_any, out_free, accept, last_acc;
  rr_pick #(.N(NUM_IN), .IW(ID_W)) u_pick (
    .req(bus.s_tvalid & bus.req_mask),
    .ptr(rr_ptr),
    .gnt_idx(pick_idx),
    .gnt_any(pick_any)
  );
  // handshake decode and next state; upstream ready only while a grant is held
  always_comb begin
    out_free = !bus.m_tvalid || bus.m_tready;
    accept = state == XFER && bus.s_tvalid[grant] && out_free;
    last_acc = accept && bus.s_tlast[grant];
    bus.s_tready = (reset_n && state == XFER && out_free) ? NUM_IN'(1) << grant : '0;
    bus.busy = reset_n && state == XFER;
    state_nxt = state == IDLE ? (pick_any ? XFER : IDLE) : (last_acc ? IDLE : XFER);
  end
  // state, grant and round-robin pointer; mask only matters when picking in IDLE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) grant <= pick_idx;
      if (last_acc) rr_ptr <= grant == LAST_ID ? '0 : grant + 1'b1;
    end
  end
  // output register: load on accept, hold under backpressure, drop valid once drained
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata <= '0;
      bus.m_tlast <= 1'b0;
      bus.m_tid <= '0;
    end else if (accept) begin
      bus.m_tvalid <= 1'b1;
      bus.m_tdata <= bus.s_tdata[grant*DATA_W +: DATA_W];
      bus.m_tlast <= bus.s_tlast[grant];
      bus.m_tid <= grant;
    end else if (bus.m_tready) begin
      bus.m_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: scoreboard bench for the packet arbiter
module tb_axis_pkt_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  axis_pkt_arbiter_if #(.NUM_IN(4), .DATA_W(8), .ID_W(2)) bus();
  axis_pkt_arbiter #(.NUM_IN(4), .DATA_W(8), .ID_W(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [10:0] sb[$];
  logic [10:0] mon_e;
  logic [8:0] mem[4][64];
  int n[4];
  int rd[4];
  logic [3:0] stall;
  logic [3:0] hs;
  logic mon_en = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic add_pkt(input int r, input int len, input logic [7:0] base, input logic [7:0] step, input bit exp);
    for (int k = 0; k < len; k++) begin
      logic [7:0] d;
      logic lst;
      d = base + 8'(k) * step;
      lst = k == len - 1;
      mem[r][n[r]] = {lst, d};
      n[r]++;
      if (exp) sb.push_back({2'(r), lst, d});
    end
  endtask
  task automatic drive();
    logic [3:0] v, l;
    logic [31:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd[i] < n[i]) begin
        v[i] = !stall[i];
        l[i] = mem[i][rd[i]][8];
        d[i*8 +: 8] = mem[i][rd[i]][7:0];
      end
    end
    bus.s_tvalid = v;
    bus.s_tlast = l;
    bus.s_tdata = d;
  endtask
  task automatic do_reset();
    mon_en = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    stall = '0;
    out_cnt = 0;
    bus.req_mask = 4'hf;
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      rd[i] = 0;
    end
    tick();
    chk("rst_tvalid", bus.m_tvalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tready", bus.s_tready, 0);
    chk("rst_tdata", bus.m_tdata, 0);
    chk("rst_tlast", bus.m_tlast, 0);
    chk("rst_tid", bus.m_tid, 0);
    tick();
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask
  task automatic wait_out(input int k);
    for (int t = 0; t < 100 && out_cnt < k; t++) tick();
    chk("wait_out", out_cnt >= k, 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) tick();
    chk("drain", sb.size(), 0);
    repeat (3) tick();
  endtask
  // requester models: advance on observed handshake, then present the next beat
  initial begin
    forever begin
      @(negedge clk);
      hs = bus.s_tvalid & bus.s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (hs[i] && rd[i] < n[i]) rd[i]++;
      drive();
    end
  end
  // output monitor: every transferred beat must match the scoreboard head
  always @(negedge clk) begin
    if (mon_en && reset_n && bus.m_tvalid && bus.m_tready) begin
      if (sb.size() == 0) chk("extra_beat", sb.size(), 1);
      else begin
        mon_e = sb.pop_front();
        chk("out_tid", bus.m_tid, mon_e[10:9]);
        chk("out_tlast", bus.m_tlast, mon_e[8]);
        chk("out_tdata", bus.m_tdata, mon_e[7:0]);
        out_cnt++;
      end
    end
  end
  initial begin
    reset_n = 1'b0;
    stall = '0;
    bus.s_tvalid = '0;
    bus.s_tlast = '0;
    bus.s_tdata = '0;
    bus.req_mask = 4'hf;
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      rd[i] = 0;
    end
    do_reset();
    add_pkt(0, 3, 8'h11, 8'h11, 1);
    tick();
    chk("idle_tready", bus.s_tready, 0);
    chk("idle_busy", bus.busy, 0);
    tick();
    chk("grant_busy", bus.busy, 1);
    chk("grant_tready", bus.s_tready, 4'b0001);
    chk("grant_tvalid", bus.m_tvalid, 0);
    tick();
    chk("b0_tvalid", bus.m_tvalid, 1);
    chk("b0_tdata", bus.m_tdata, 8'h11);
    chk("b0_tlast", bus.m_tlast, 0);
    tick();
    chk("b1_tdata", bus.m_tdata, 8'h22);
    tick();
    chk("b2_tdata", bus.m_tdata, 8'h33);
    chk("b2_tlast", bus.m_tlast, 1);
    chk("b2_busy", bus.busy, 0);
    drain();
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) add_pkt(r, 2, 8'(8'h80 + p * 16 + r * 4), 8'h01, 1);
    drain();
    do_reset();
    add_pkt(0, 6, 8'h40, 8'h01, 1);
    wait_out(2);
    bus.m_tready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("bp_tvalid", bus.m_tvalid, 1);
      chk("bp_tready", bus.s_tready, 0);
      chk("bp_hold", bus.m_tdata, sb[0][7:0]);
    end
    bus.m_tready = 1'b1;
    drain();
    do_reset();
    bus.req_mask = 4'b1010;
    add_pkt(1, 4, 8'h10, 8'h01, 1);
    add_pkt(3, 2, 8'h30, 8'h01, 1);
    add_pkt(1, 2, 8'h18, 8'h01, 1);
    add_pkt(3, 2, 8'h38, 8'h01, 1);
    add_pkt(0, 2, 8'h00, 8'h01, 0);
    add_pkt(2, 2, 8'h20, 8'h01, 0);
    wait_out(1);
    bus.req_mask = 4'b0000;
    stall[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("mask_busy", bus.busy, 1);
      chk("mask_tready", bus.s_tready, 4'b0010);
    end
    stall[1] = 1'b0;
    bus.req_mask = 4'b1010;
    drain();
    chk("mask_idle", bus.busy, 0);
    do_reset();
    add_pkt(0, 4, 8'h50, 8'h01, 1);
    wait_out(1);
    stall[0] = 1'b1;
    add_pkt(2, 2, 8'h60, 8'h01, 1);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("stall_busy", bus.busy, 1);
      chk("stall_tready", bus.s_tready, 4'b0001);
    end
    stall[0] = 1'b0;
    drain();
    do_reset();
    add_pkt(0, 4, 8'h70, 8'h01, 1);
    wait_out(2);
    do_reset();
    add_pkt(3, 2, 8'h90, 8'h01, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
